count_down_module: RTL and testbench
====================================

Name: count_down_module

Overview:
- Loadable down-counter/timer that complements the existing up-counter (`count_module`).
- Accepts a start value through a valid/ready load handshake and decrements it to zero under an enable.
- Flags expiry with a one-cycle `done` pulse, then either auto-reloads or returns to idle.
- Used as the countdown/timeout partner of the up-counter in the same exercise set.

Parameters:
- WIDTH, 4, width of count value and load value.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  load request; load_value is valid while high.
- load_ready  output  1  block can accept a load (high in IDLE only).
- load_value  input  WIDTH  start/reload value.
- en  input  1  decrement enable while running.
- stop  input  1  abort the current run.
- reload_en  input  1  on expiry, restart from the stored reload value.
- number  output  WIDTH  current count.
- zero  output  1  number == 0.
- done  output  1  one-cycle pulse on expiry.
- busy  output  1  state == RUN.

Behaviour:
- Reset (rst=1 at an edge), all registered:
  - state=IDLE, number=0, reload_reg=0, done=0.
  - Hence zero=1, busy=0, load_ready=1.
- Output derivation:
  - zero is derived from number and must equal (number==0) every cycle.
  - load_ready = (state==IDLE); busy = (state==RUN).
- Load acceptance: load_valid && load_ready at an edge. At that edge:
  - number <= load_value; reload_reg <= load_value.
  - load_value != 0: state <= RUN, done stays 0.
  - load_value == 0: state stays IDLE, done <= 1 for exactly one cycle (immediate expiry), no reload regardless of reload_en.
- load_valid while in RUN: ignored (load_ready=0), no state change; the requester must hold load_valid until ready.
- RUN, en=0: number holds, no done.
- RUN, en=1, number > 1: number <= number-1.
- RUN, en=1, number == 1: number <= 0; done <= 1 at the same edge, so done and zero assert together for one cycle.
- Cycle after expiry (RUN with number==0), resolved at the next edge regardless of en:
  - reload_en=1 and reload_reg != 0: number <= reload_reg, stay RUN.
  - otherwise: state <= IDLE, number holds 0.
  - done <= 0.
- Auto-reload period for value N with en held high: N+1 cycles (N, N-1, …, 1, 0), done once per period.
- stop=1 in RUN at any edge: state <= IDLE, number holds its current value, done <= 0.
  - stop has priority over decrement, expiry and reload.
  - If number==1, en=1 and stop=1 on the same edge: number stays 1, no done.
- stop in IDLE: no effect. A load and stop arriving in the same IDLE cycle: load wins.
- done is never asserted for two consecutive cycles.
- rst has priority over everything, including a mid-run or same-cycle load.
- Width rules:
  - No wrap-around: number never decrements below 0; underflow is impossible by construction.
  - The reload value equals the most recently accepted load_value.

Decomposition:
- Shared package `count_pkg`:
  - state enum typedef cd_state_t {IDLE, RUN}, 1-bit encoding.
  - Default WIDTH constant, shared with `count_module`.
- No sub-module: the FSM and counter datapath stay in one module.
- The bench carries its own reference model (expected number/done per edge).

Test Plan:
- Reset → number=0, zero=1, done=0, load_ready=1, busy=0; hold rst 2 cycles, then release.
- Load 5, en=1, reload_en=0 →
  - number 5,4,3,2,1,0 on successive cycles;
  - done=1 only in the cycle number==0;
  - next cycle busy=0, load_ready=1, number stays 0.
- Load 3, reload_en=1, en=1 for 12 cycles →
  - sequence 3,2,1,0,3,2,1,0,3,2,1,0;
  - done pulses exactly 3 times, 4 cycles apart.
- Load 6, en toggled 1,0,0,1 →
  - number 6→5, holds 5 for 2 cycles, →4;
  - load_valid with value 9 during RUN is ignored (number unaffected, load_ready=0).
- Load 2; at number==1 assert en=1 and stop=1 together →
  - number stays 1, no done, state IDLE;
  - a new load of 4 is accepted next cycle.
- Load 0 → done pulses one cycle, zero=1, busy never asserts; then rst asserted mid-run of a load of 15 → next cycle number=0, IDLE.

Source files
------------

// File: rtl/count_pkg.sv
// Shared definitions for the up/down counter exercise set.
package count_pkg;

    // Default counter width, shared with count_module.
    localparam int COUNT_WIDTH = 4;

    // One bit is enough for the two-state down-counter FSM.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cd_state_t;

endpackage : count_pkg

// File: rtl/count_down_module.sv
// Loadable down-counter/timer with valid/ready load, stop and auto-reload.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | waiting for a load; load_ready high, number holds its last value
//  RUN   | counting down under en; at zero either reload or return to IDLE
module count_down_module
    import count_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             stop,
    input  logic             reload_en,
    output logic [WIDTH-1:0] number,
    output logic             zero,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    cd_state_t        state_q, state_d;
    logic [WIDTH-1:0] number_q, number_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    // State, count, reload value and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            number_q <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            number_q <= number_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: stop beats expiry/reload, which beats decrement.
    always_comb begin
        state_d  = state_q;
        number_d = number_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    number_d = load_value;
                    reload_d = load_value;
                    if (load_value != ZERO_VAL) begin
                        state_d = RUN;
                    end else begin
                        // Immediate expiry; back-to-back zero loads must not
                        // stretch done into a two-cycle pulse.
                        done_d = !done_q;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (number_q == ZERO_VAL) begin
                    if (reload_en && (reload_q != ZERO_VAL)) begin
                        number_d = reload_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (en) begin
                    number_d = number_q - ONE_VAL;
                    done_d   = (number_q == ONE_VAL);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign number     = number_q;
    assign zero       = (number_q == ZERO_VAL);
    assign done       = done_q;
    assign busy       = (state_q == RUN);
    assign load_ready = (state_q == IDLE);

endmodule : count_down_module

// File: tb/tb_count_down_module.sv
// Directed bench for count_down_module with a reference model feeding a scoreboard.
module tb_count_down_module;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_value;
    logic         en;
    logic         stop;
    logic         reload_en;
    logic [W-1:0] number;
    logic         zero;
    logic         done;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int done_count;

    typedef struct {
        logic [W-1:0] num;
        logic         zero;
        logic         done;
        logic         busy;
        logic         ready;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic         m_run;
    logic [W-1:0] m_num;
    logic [W-1:0] m_rel;
    logic         m_done;

    count_down_module #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .en         (en),
        .stop       (stop),
        .reload_en  (reload_en),
        .number     (number),
        .zero       (zero),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, push its prediction,
    // then compare the DUT after the edge against the popped entry.
    task automatic step(input logic lv, input logic [W-1:0] val, input logic e,
                        input logic s, input logic re, input logic r);
        exp_t x;
        exp_t got;
        logic         n_run;
        logic [W-1:0] n_num;
        logic [W-1:0] n_rel;
        logic         n_done;
        @(negedge clk);
        load_valid = lv;
        load_value = val;
        en         = e;
        stop       = s;
        reload_en  = re;
        rst        = r;
        n_run  = m_run;
        n_num  = m_num;
        n_rel  = m_rel;
        n_done = 1'b0;
        if (r) begin
            n_run = 1'b0; n_num = '0; n_rel = '0;
        end else if (!m_run) begin
            if (lv) begin
                n_num = val;
                n_rel = val;
                if (val == 0) n_done = !m_done;
                else          n_run  = 1'b1;
            end
        end else if (s) begin
            n_run = 1'b0;
        end else if (m_num == 0) begin
            if (re && m_rel != 0) n_num = m_rel;
            else                  n_run = 1'b0;
        end else if (e) begin
            n_num  = m_num - 1'b1;
            n_done = (m_num == 1);
        end
        m_run = n_run; m_num = n_num; m_rel = n_rel; m_done = n_done;
        x.num   = m_num;
        x.zero  = (m_num == 0);
        x.done  = m_done;
        x.busy  = m_run;
        x.ready = !m_run;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_val("number",     int'(number),     int'(got.num));
        check_val("zero",       int'(zero),       int'(got.zero));
        check_val("done",       int'(done),       int'(got.done));
        check_val("busy",       int'(busy),       int'(got.busy));
        check_val("load_ready", int'(load_ready), int'(got.ready));
        if (done === 1'b1) done_count++;
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_value = '0;
        en = 1'b0; stop = 1'b0; reload_en = 1'b0;
        m_run = 1'b0; m_num = '0; m_rel = '0; m_done = 1'b0;
        done_count = 0;

        // Reset held two cycles, then released
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check_val("reset_number", int'(number), 0);
        check_val("reset_ready",  int'(load_ready), 1);
        step(0, 0, 0, 0, 0, 0);

        // Load 5, count down to 0 without reload, then drop to IDLE
        done_count = 0;
        step(1, 5, 1, 0, 0, 0);
        check_val("load5_number", int'(number), 5);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
        check_val("load5_done_at_zero", int'(done), 1);
        step(0, 0, 1, 0, 0, 0);
        check_val("load5_idle_busy", int'(busy), 0);
        check_val("load5_done_total", done_count, 1);

        // Load 3 with auto-reload for 12 cycles
        done_count = 0;
        step(1, 3, 1, 0, 1, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 1, 0);
        check_val("reload_done_pulses", done_count, 3);
        check_val("reload_last_number", int'(number), 0);
        step(0, 0, 1, 0, 0, 0);
        check_val("reload_off_idle", int'(busy), 0);

        // Load 6, en 1,0,0,1 with an ignored load of 9 while running
        step(1, 6, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 9, 0, 0, 0, 0);
        check_val("ignored_load_number", int'(number), 5);
        step(1, 9, 1, 0, 0, 0);
        check_val("en_resume_number", int'(number), 4);
        step(0, 0, 1, 1, 0, 0);

        // Load 2; stop together with en at number==1
        done_count = 0;
        step(1, 2, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        check_val("stop_number_holds", int'(number), 1);
        check_val("stop_no_done", done_count, 0);
        step(1, 4, 1, 0, 0, 0);
        check_val("load_after_stop", int'(number), 4);
        step(0, 0, 0, 1, 0, 0);

        // Stop in IDLE alongside a load: load wins
        step(1, 7, 0, 1, 0, 0);
        check_val("load_beats_stop", int'(busy), 1);
        step(0, 0, 0, 1, 0, 0);

        // Load 0: immediate expiry, never busy
        step(1, 0, 1, 0, 1, 0);
        check_val("load0_done", int'(done), 1);
        step(1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);

        // Reset mid-run of a load of 15, with a load request present
        step(1, 15, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(1, 9, 1, 0, 0, 1);
        check_val("rst_midrun_number", int'(number), 0);
        check_val("rst_midrun_busy", int'(busy), 0);
        step(0, 0, 0, 0, 0, 0);

        check_val("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_count_down_module
